// File: rtl/s3_writeback_regfile_if.sv
// Bundle of S3 writeback and decode read-port signals for the architectural register file.
// The master is the pipeline side; the slave is the register file.
interface s3_writeback_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] S3_Result;
  logic [ADDR_WIDTH-1:0] S3_WriteSelect;
  logic                  S3_WriteEnable;
  logic [ADDR_WIDTH-1:0] ReadSelect1;
  logic [ADDR_WIDTH-1:0] ReadSelect2;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;

  modport master (
    output S3_Result, S3_WriteSelect, S3_WriteEnable, ReadSelect1, ReadSelect2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  S3_Result, S3_WriteSelect, S3_WriteEnable, ReadSelect1, ReadSelect2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/s3_writeback_regfile.sv
// Architectural register file: commits S3 results, serves two combinational read ports,
// r0 hardwired to zero, optional same-cycle write-to-read bypass.
module s3_writeback_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  s3_writeback_regfile_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  commit;
  logic                  bypass1;
  logic                  bypass2;

  assign commit = !rst && bus.S3_WriteEnable && (bus.S3_WriteSelect != '0);

  // NOTE: every entry must clear on one edge, so the array is built from flops with a
  // reset term rather than a RAM macro, which could not be cleared in a single cycle.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned
    // and a latch gets inferred.
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_d[i] = '0;
    end else if (commit) begin
      regs_d[bus.S3_WriteSelect] = bus.S3_Result;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops sample together.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Bypass needs the same qualifiers as a commit plus an address match on a nonzero port.
  assign bypass1 = BYPASS_EN && commit && (bus.S3_WriteSelect == bus.ReadSelect1);
  assign bypass2 = BYPASS_EN && commit && (bus.S3_WriteSelect == bus.ReadSelect2);

  always_comb begin
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    if (bus.ReadSelect1 != '0) bus.ReadData1 = bypass1 ? bus.S3_Result : regs_q[bus.ReadSelect1];
    if (bus.ReadSelect2 != '0) bus.ReadData2 = bypass2 ? bus.S3_Result : regs_q[bus.ReadSelect2];
  end
endmodule

// File: tb/tb_s3_writeback_regfile.sv
// Scoreboard bench: drives a bypass and a non-bypass instance with identical directed
// vectors; a negedge monitor pops hand-computed expectations and compares all read ports.
module tb_s3_writeback_regfile;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    string         name;
    logic [DW-1:0] b1, b2;  // bypass instance
    logic [DW-1:0] n1, n2;  // non-bypass instance
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  s3_writeback_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();
  s3_writeback_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_n ();

  s3_writeback_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS_EN(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  s3_writeback_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS_EN(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.slave)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus to both instances, queue the expectation, advance a cycle.
  task automatic step(input string name, input logic r, input logic we,
                      input logic [AW-1:0] ws, input logic [DW-1:0] wd,
                      input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                      input logic [DW-1:0] b1, input logic [DW-1:0] b2,
                      input logic [DW-1:0] n1, input logic [DW-1:0] n2);
    exp_t e;
    rst = r;
    bus_b.S3_WriteEnable = we; bus_n.S3_WriteEnable = we;
    bus_b.S3_WriteSelect = ws; bus_n.S3_WriteSelect = ws;
    bus_b.S3_Result      = wd; bus_n.S3_Result      = wd;
    bus_b.ReadSelect1    = rs1; bus_n.ReadSelect1   = rs1;
    bus_b.ReadSelect2    = rs2; bus_n.ReadSelect2   = rs2;
    e.name = name; e.b1 = b1; e.b2 = b2; e.n1 = n1; e.n2 = n2;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle before the committing edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, " byp rd1"}, bus_b.ReadData1, e.b1);
        check({e.name, " byp rd2"}, bus_b.ReadData2, e.b2);
        check({e.name, " nobyp rd1"}, bus_n.ReadData1, e.n1);
        check({e.name, " nobyp rd2"}, bus_n.ReadData2, e.n2);
      end
    end
  end

  initial begin
    logic [DW-1:0] old_n;
    logic [AW-1:0] a, b;
    bus_b.S3_WriteEnable = 1'b0; bus_n.S3_WriteEnable = 1'b0;
    bus_b.S3_WriteSelect = '0;   bus_n.S3_WriteSelect = '0;
    bus_b.S3_Result      = '0;   bus_n.S3_Result      = '0;
    bus_b.ReadSelect1    = '0;   bus_n.ReadSelect1    = '0;
    bus_b.ReadSelect2    = '0;   bus_n.ReadSelect2    = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 32; i++) begin
      a = AW'(i); b = AW'(31 - i);
      step("reset sweep", 0, 0, 0, 0, a, b, 0, 0, 0, 0);
    end

    step("write r5", 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step("read r5", 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    step("read r4 r6", 0, 0, 0, 0, 4, 6, 0, 0, 0, 0);

    step("bypass r7", 0, 1, 7, 32'h12345678, 7, 5, 32'h12345678, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    step("after r7", 0, 0, 0, 0, 7, 7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);

    step("write r0", 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    step("after r0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("r3=A", 0, 1, 3, 32'hA, 3, 0, 32'hA, 0, 0, 0);
    step("r3=B", 0, 1, 3, 32'hB, 3, 3, 32'hB, 32'hB, 32'hA, 32'hA);
    step("r3=C", 0, 1, 3, 32'hC, 3, 3, 32'hC, 32'hC, 32'hB, 32'hB);
    step("we low r3", 0, 0, 3, 32'h99, 3, 3, 32'hC, 32'hC, 32'hC, 32'hC);
    step("r3 held", 0, 0, 0, 0, 3, 3, 32'hC, 32'hC, 32'hC, 32'hC);

    for (int i = 1; i < 32; i++) begin
      a = AW'(i); b = AW'(i - 1);
      case (i)
        3:       old_n = 32'hC;
        5:       old_n = 32'hDEADBEEF;
        7:       old_n = 32'h12345678;
        default: old_n = 32'h0;
      endcase
      step("fill", 0, 1, a, DW'(i), a, b, DW'(i), DW'(i - 1), old_n, DW'(i - 1));
    end
    step("filled", 0, 0, 0, 0, 9, 31, 32'd9, 32'd31, 32'd9, 32'd31);

    step("reset with write", 1, 1, 9, 32'h55, 9, 31, 32'd9, 32'd31, 32'd9, 32'd31);
    for (int i = 0; i < 32; i++) begin
      a = AW'(i); b = AW'((i + 9) % 32);
      step("post-reset sweep", 0, 0, 0, 0, a, b, 0, 0, 0, 0);
    end

    step("dual bypass", 0, 1, 12, 32'hCAFEF00D, 12, 12, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    step("after r12", 0, 0, 0, 0, 12, 12, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
    step("x data we low", 0, 0, 12, 'x, 12, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);
    step("x data held", 0, 0, 0, 0, 12, 12, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/s3_writeback_regfile.md
Name: s3_writeback_regfile

Overview:
- Architectural register file at the end of the pipeline; consumes the S3 stage outputs (result, write select, write enable) and commits them.
- Provides two combinational read ports to the decode/S1 stage.
- Optional same-cycle write-to-read bypass removes the writeback-to-decode hazard.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the S3 result.
- ADDR_WIDTH, 5, register select width; depth = 2**ADDR_WIDTH (32 entries).
- BYPASS_EN, 1, 1 = forward the S3 write data to a matching read port in the same cycle; 0 = reads return array contents only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- S3_Result  input  DATA_WIDTH  writeback data from the S3 stage.
- S3_WriteSelect  input  ADDR_WIDTH  destination register.
- S3_WriteEnable  input  1  commit S3_Result this cycle.
- ReadSelect1  input  ADDR_WIDTH  read port 1 address.
- ReadSelect2  input  ADDR_WIDTH  read port 2 address.
- ReadData1  output  DATA_WIDTH  read port 1 data, combinational.
- ReadData2  output  DATA_WIDTH  read port 2 data, combinational.

Behaviour:
- Reset: on any rising edge with rst=1, all 2**ADDR_WIDTH entries are cleared to 0 in that single edge. A write presented in the same cycle is discarded.
- After the first reset edge, ReadData1/2 read 0 for every address. There is no output register, so the outputs have no reset value of their own.
- Reset mid-operation: the array is cleared on that edge and prior contents are lost. Writes resume on the first edge with rst=0.
- Write:
  - Occurs on a rising edge when rst=0, S3_WriteEnable=1 and S3_WriteSelect!=0; entry[S3_WriteSelect] <= S3_Result.
  - Write latency: 1 edge. The array value is visible on the read ports from the following cycle.
- Register 0: writes with S3_WriteSelect=0 are dropped. Reading address 0 always returns 0, including the bypass case.
- Read: ReadDataN = 0 if ReadSelectN==0. Otherwise ReadDataN = entry[ReadSelectN], subject to the bypass rule below.
- Bypass: when BYPASS_EN=1, ReadDataN = S3_Result if all of the following hold:
  - rst=0
  - S3_WriteEnable=1
  - S3_WriteSelect==ReadSelectN
  - ReadSelectN!=0
- Bypass is evaluated independently per port; both ports may bypass in the same cycle.
- While rst=1, bypass is suppressed and ports show array contents.
- BYPASS_EN=0: a same-cycle read of the register being written returns the old value. The new value appears on the next cycle.
- Back-to-back writes to the same register: last write wins, one per edge. No write merging.
- Write enable low: the array is unchanged regardless of S3_Result or S3_WriteSelect values.
- Both read ports may address the same register and return identical data.
- No X propagation from unused inputs: when S3_WriteEnable=0, S3_Result must not affect any output.

Test Plan:
- Reset, then sweep ReadSelect1/2 over 0..31 -> every ReadData = 0x00000000.
- Write 0xDEADBEEF to r5 (WE=1 for one cycle); next cycle read r5 on both ports -> 0xDEADBEEF on both. Read r4 and r6 -> 0.
- BYPASS_EN=1: in the same cycle, WE=1, sel=7, data=0x12345678, ReadSelect1=7 -> ReadData1=0x12345678 before the edge. Repeat with BYPASS_EN=0 -> old value (0) before the edge, 0x12345678 after.
- Write 0xFFFFFFFF to r0 with ReadSelect1=0 in the same cycle -> ReadData1=0 in that cycle and all subsequent cycles.
- Write r3=0xA, r3=0xB, r3=0xC on consecutive edges -> r3 reads 0xA, 0xB, 0xC on the cycle after each edge. WE=0 with sel=3, data=0x99 -> r3 stays 0xC.
- Fill r1..r31 with their index, then assert rst for one cycle with WE=1, sel=9, data=0x55 -> after the edge all registers read 0 and r9 != 0x55. Bypass does not drive 0x55 while rst=1.
